// File: rtl/dgs_blink_codes.sv
// Multi-channel diagnostic blinker: serves channels with non-zero codes round-robin,
// blinking the channel ID as long pulses, then the code as short pulses, then a pause.
module dgs_blink_codes #(
  parameter int FREQ_HZ  = 100_000_000,
  parameter int QUANT_US = 250_000,
  parameter int N_CH     = 4,
  parameter int CODE_W   = 4,
  parameter int LONG_Q   = 3,
  parameter int GAP_Q    = 4,
  parameter int PAUSE_Q  = 8,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_CH*CODE_W-1:0]   CODES,
  output logic                     LED_OUT,
  output logic                     BUSY,
  output logic [CH_W-1:0]          ACTIVE_CH,
  output logic                     FRAME_START
);

  // state     | meaning
  // S_IDLE    | no frame; searches for an active channel on each tick
  // S_ID_ON   | long ID pulse, LED lit for LONG_Q quants
  // S_ID_OFF  | 1 quant dark between ID pulses
  // S_GAP     | GAP_Q quants dark between ID group and code group
  // S_CODE_ON | short code pulse, LED lit for 1 quant
  // S_CODE_OFF| 1 quant dark between code pulses
  // S_PAUSE   | PAUSE_Q quants dark closing the frame

  localparam int QUANT_DIV = (FREQ_HZ / 1_000_000) * QUANT_US;
  localparam int PRE_W     = $clog2(QUANT_DIV);
  localparam int MAX_Q     = (LONG_Q > GAP_Q) ? ((LONG_Q > PAUSE_Q) ? LONG_Q : PAUSE_Q)
                                              : ((GAP_Q > PAUSE_Q) ? GAP_Q : PAUSE_Q);
  localparam int QCNT_W    = $clog2(MAX_Q + 1);

  localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(QUANT_DIV - 1);
  localparam logic [QCNT_W-1:0] LONG_LOAD  = QCNT_W'(LONG_Q - 1);
  localparam logic [QCNT_W-1:0] GAP_LOAD   = QCNT_W'(GAP_Q - 1);
  localparam logic [QCNT_W-1:0] PAUSE_LOAD = QCNT_W'(PAUSE_Q - 1);
  localparam logic [CH_W-1:0]   CH_LAST    = CH_W'(N_CH - 1);
  localparam logic [CH_W:0]     ID_ONE     = (CH_W+1)'(1);
  localparam logic [CODE_W-1:0] CODE_ONE   = CODE_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_ID_ON, S_ID_OFF, S_GAP, S_CODE_ON, S_CODE_OFF, S_PAUSE
  } state_t;

  state_t              state_q, state_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [QCNT_W-1:0]   qcnt_q, qcnt_d;
  logic [CH_W:0]       id_left_q, id_left_d;
  logic [CODE_W-1:0]   code_left_q, code_left_d;
  logic [CH_W-1:0]     rr_next_q, rr_next_d;
  logic [CH_W-1:0]     active_ch_q, active_ch_d;
  logic                led_q, led_d;
  logic                busy_q, busy_d;
  logic                fs_q, fs_d;

  logic                tick;
  logic                hit;
  logic [CH_W-1:0]     hit_ch;
  logic [CODE_W-1:0]   hit_code;

  assign tick = (pre_q == PRE_LAST);

  // Pick the non-zero channel closest to rr_next in modulo-N_CH order.
  always_comb begin
    int off;
    int best_off;
    hit      = 1'b0;
    hit_ch   = '0;
    hit_code = '0;
    best_off = N_CH;
    off      = 0;
    for (int j = 0; j < N_CH; j++) begin
      off = j - int'(rr_next_q);
      if (off < 0) off = off + N_CH;
      if ((CODES[j*CODE_W +: CODE_W] != '0) && (off < best_off)) begin
        best_off = off;
        hit      = 1'b1;
        hit_ch   = CH_W'(j);
        hit_code = CODES[j*CODE_W +: CODE_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    qcnt_d      = qcnt_q;
    id_left_d   = id_left_q;
    code_left_d = code_left_q;
    rr_next_d   = rr_next_q;
    active_ch_d = active_ch_q;
    fs_d        = 1'b0;
    pre_d       = tick ? '0 : pre_q + 1'b1;

    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (hit) begin
            active_ch_d = hit_ch;
            rr_next_d   = (hit_ch == CH_LAST) ? '0 : hit_ch + 1'b1;
            id_left_d   = {1'b0, hit_ch} + 1'b1;
            code_left_d = hit_code;
            qcnt_d      = LONG_LOAD;
            state_d     = S_ID_ON;
            fs_d        = 1'b1;
          end
        end
        S_ID_ON: begin
          if (qcnt_q == '0) begin
            id_left_d = id_left_q - 1'b1;
            if (id_left_q == ID_ONE) begin
              state_d = S_GAP;
              qcnt_d  = GAP_LOAD;
            end else begin
              state_d = S_ID_OFF;
              qcnt_d  = '0;
            end
          end else begin
            qcnt_d = qcnt_q - 1'b1;
          end
        end
        S_ID_OFF: begin
          state_d = S_ID_ON;
          qcnt_d  = LONG_LOAD;
        end
        S_GAP: begin
          if (qcnt_q == '0) begin
            state_d = S_CODE_ON;
            qcnt_d  = '0;
          end else begin
            qcnt_d = qcnt_q - 1'b1;
          end
        end
        S_CODE_ON: begin
          code_left_d = code_left_q - 1'b1;
          if (code_left_q == CODE_ONE) begin
            state_d = S_PAUSE;
            qcnt_d  = PAUSE_LOAD;
          end else begin
            state_d = S_CODE_OFF;
            qcnt_d  = '0;
          end
        end
        S_CODE_OFF: begin
          state_d = S_CODE_ON;
          qcnt_d  = '0;
        end
        S_PAUSE: begin
          if (qcnt_q == '0) begin
            state_d = S_IDLE;
          end else begin
            qcnt_d = qcnt_q - 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    led_d  = (state_d == S_ID_ON) || (state_d == S_CODE_ON);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      pre_q       <= '0;
      qcnt_q      <= '0;
      id_left_q   <= '0;
      code_left_q <= '0;
      rr_next_q   <= '0;
      active_ch_q <= '0;
      led_q       <= 1'b0;
      busy_q      <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      qcnt_q      <= qcnt_d;
      id_left_q   <= id_left_d;
      code_left_q <= code_left_d;
      rr_next_q   <= rr_next_d;
      active_ch_q <= active_ch_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
      fs_q        <= fs_d;
    end
  end

  assign LED_OUT     = led_q;
  assign BUSY        = busy_q;
  assign ACTIVE_CH   = active_ch_q;
  assign FRAME_START = fs_q;

endmodule
